// File: rtl/rf_fix_ctrl_pkg.sv
// Shared register-file types plus the constants and state encoding used by the
// correctable-error repair scheduler.
package p_hardisc;

    typedef logic [4:0] rf_add;

    localparam int RFFIX_STARVE_LIM = 4;

    typedef enum logic [1:0] {
        RFFIX_IDLE  = 2'd0,
        RFFIX_WAIT  = 2'd1,
        RFFIX_FORCE = 2'd2
    } rffix_state;

endpackage

// File: rtl/rf_fix_queue.sv
// Two-entry oldest-first repair queue with merge on address match, invalidate on
// pipeline write, and push/pop in the same cycle.
module rf_fix_queue
    import p_hardisc::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pop,
    input  logic        inv_en,
    input  rf_add       inv_addr,
    input  logic        push1,
    input  rf_add       addr1,
    input  logic [31:0] val1,
    input  logic        push2,
    input  rf_add       addr2,
    input  logic [31:0] val2,
    output logic        head_valid,
    output rf_add       head_addr,
    output logic [31:0] head_val,
    output logic        empty_next,
    output logic        drop
);

    logic [1:0]  valid_q, valid_d;
    rf_add       addr_q[2], addr_d[2];
    logic [31:0] val_q[2], val_d[2];
    logic        drop_d;
    logic        keep0, keep1, merge1, merge2;

    // Entry 0 is always the head; survivors are compacted towards it.
    assign keep0  = valid_q[0] & ~pop & ~(inv_en && (addr_q[0] == inv_addr));
    assign keep1  = valid_q[1] & ~(inv_en && (addr_q[1] == inv_addr));
    assign merge1 = (valid_q[0] && (addr_q[0] == addr1)) || (valid_q[1] && (addr_q[1] == addr1));
    assign merge2 = (valid_q[0] && (addr_q[0] == addr2)) || (valid_q[1] && (addr_q[1] == addr2));

    always_comb begin
        valid_d = 2'b00;
        addr_d  = addr_q;
        val_d   = val_q;
        drop_d  = 1'b0;

        if (keep0) begin
            valid_d[0] = 1'b1;
            if (keep1) valid_d[1] = 1'b1;
        end else if (keep1) begin
            valid_d[0] = 1'b1;
            addr_d[0]  = addr_q[1];
            val_d[0]   = val_q[1];
        end

        if (push1 && !merge1) begin
            if (!valid_d[0]) begin
                valid_d[0] = 1'b1;
                addr_d[0]  = addr1;
                val_d[0]   = val1;
            end else if (!valid_d[1]) begin
                valid_d[1] = 1'b1;
                addr_d[1]  = addr1;
                val_d[1]   = val1;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (push2 && !merge2) begin
            if (!valid_d[0]) begin
                valid_d[0] = 1'b1;
                addr_d[0]  = addr2;
                val_d[0]   = val2;
            end else if (!valid_d[1]) begin
                valid_d[1] = 1'b1;
                addr_d[1]  = addr2;
                val_d[1]   = val2;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 2'b00;
            drop    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            drop    <= drop_d;
        end
        addr_q <= addr_d;
        val_q  <= val_d;
    end

    assign head_valid = valid_q[0];
    assign head_addr  = addr_q[0];
    assign head_val   = val_q[0];
    assign empty_next = ~|valid_d;

endmodule

// File: rtl/rf_fix_ctrl.sv
// Repair scheduler: captures corrected source values flagged by the OP stage and
// writes them back through the RF write port whenever the pipeline leaves it idle.
module rf_fix_ctrl
    import p_hardisc::*;
#(
    parameter int STARVE_LIM = RFFIX_STARVE_LIM
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_ce_en_i,
    input  logic [1:0]  s_ce_i,
    input  rf_add       s_rs1_i,
    input  rf_add       s_rs2_i,
    input  logic [31:0] s_val1_i,
    input  logic [31:0] s_val2_i,
    input  logic        s_wb_we_i,
    input  rf_add       s_wb_rd_i,
    input  logic [31:0] s_wb_val_i,
    output logic        s_rf_we_o,
    output rf_add       s_rf_rd_o,
    output logic [31:0] s_rf_val_o,
    output logic        s_busy_o,
    output logic        s_hold_o,
    output logic        s_fixed_o,
    output logic        s_drop_o
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    rffix_state  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        cand1, cand2, grant, deny, empty_next;
    logic        head_valid;
    rf_add       head_addr;
    logic [31:0] head_val;

    // A source the WB stage is rewriting this cycle already gets a newer value.
    assign cand1 = s_ce_en_i & s_ce_i[0] & (s_rs1_i != '0) & ~(s_wb_we_i && (s_rs1_i == s_wb_rd_i));
    assign cand2 = s_ce_en_i & s_ce_i[1] & (s_rs2_i != '0) & ~(s_wb_we_i && (s_rs2_i == s_wb_rd_i))
                 & ~(cand1 && (s_rs1_i == s_rs2_i));

    assign grant = ~s_wb_we_i & head_valid & s_resetn_i;
    assign deny  = s_wb_we_i & head_valid;

    rf_fix_queue u_queue (
        .clk        (s_clk_i),
        .resetn     (s_resetn_i),
        .pop        (grant),
        .inv_en     (s_wb_we_i),
        .inv_addr   (s_wb_rd_i),
        .push1      (cand1),
        .addr1      (s_rs1_i),
        .val1       (s_val1_i),
        .push2      (cand2),
        .addr2      (s_rs2_i),
        .val2       (s_val2_i),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_val   (head_val),
        .empty_next (empty_next),
        .drop       (s_drop_o)
    );

    always_comb begin
        s_rf_we_o  = s_wb_we_i;
        s_rf_rd_o  = s_wb_rd_i;
        s_rf_val_o = s_wb_val_i;
        s_fixed_o  = 1'b0;
        if (grant) begin
            s_rf_we_o  = 1'b1;
            s_rf_rd_o  = head_addr;
            s_rf_val_o = head_val;
            s_fixed_o  = 1'b1;
        end
    end

    assign cnt_inc = (cnt_q == LIM) ? LIM : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (empty_next) begin
            state_d = RFFIX_IDLE;
            cnt_d   = '0;
        end else if (state_q == RFFIX_IDLE || grant) begin
            state_d = RFFIX_WAIT;
            cnt_d   = '0;
        end else if (deny) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LIM) state_d = RFFIX_FORCE;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_q  <= RFFIX_IDLE;
            cnt_q    <= '0;
            s_busy_o <= 1'b0;
            s_hold_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_busy_o <= (state_d != RFFIX_IDLE);
            s_hold_o <= (state_d == RFFIX_FORCE);
        end
    end

endmodule

// File: doc/rf_fix_ctrl.md
# rf_fix_ctrl

Correctable-error repair scheduler for the register file. It sits between the OP stage and the register-file write port. It captures the corrected value of any source register the OP stage reports as holding a correctable ECC error. It then writes that value back through the shared RF write port, which it arbitrates against the pipeline WB write. Pipeline writes always win; a starvation counter forces a pipeline hold so the repair eventually lands.

## Interface
Parameters:
- STARVE_LIM, 4, consecutive denied cycles before s_hold_o asserts; legal range 1..15.

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset; synchronous, active-low
- s_ce_en_i  in  1  OP stage is presenting a valid, non-stalled, non-flushed instruction this cycle
- s_ce_i  in  2  correctable error flags; bit0 = rs1, bit1 = rs2
- s_rs1_i, s_rs2_i  in  rf_add (5)  source addresses
- s_val1_i, s_val2_i  in  32  corrected read data for rs1 and rs2
- s_wb_we_i  in  1  pipeline write request
- s_wb_rd_i  in  rf_add  pipeline write address
- s_wb_val_i  in  32  pipeline write data
- s_rf_we_o  out  1  RF write enable
- s_rf_rd_o  out  rf_add  RF write address
- s_rf_val_o  out  32  RF write data
- s_busy_o  out  1  at least one repair pending
- s_hold_o  out  1  request to the pipeline to insert a WB bubble
- s_fixed_o  out  1  a repair write is granted this cycle
- s_drop_o  out  1  a reported error could not be queued (registered, 1-cycle pulse)

## Operation
- Two-entry FIFO; each entry holds {valid, addr, val}. Service order is oldest first.
- A capture candidate exists for bit k when s_ce_en_i & s_ce_i[k] and rsk != 0.
  - No candidate when rsk == s_wb_rd_i with s_wb_we_i high in the same cycle, because the WB value is newer.
  - If rs1 == rs2, only one candidate (rs1's) is taken.
- A candidate whose address matches a valid entry is merged: no new entry, and no value update.
- Remaining candidates fill free entries, rs1 before rs2. Any candidate left without a slot raises s_drop_o next cycle; the instruction is restarted upstream, so the error reappears.
- Invalidation: a pipeline write (s_wb_we_i) whose address matches a valid entry clears that entry on the same edge.
- Write-port mux:
  - If s_wb_we_i: pass WB through.
  - Else if the head entry is valid: drive the head entry, assert s_fixed_o, and pop the head at the edge.
  - Else: s_rf_we_o = 0.
- The mux is purely combinational.
- FSM states:
  - IDLE: no valid entry.
  - WAIT: an entry is valid; the counter increments on each cycle s_wb_we_i denies the port and clears on a grant.
  - FORCE: entered when the counter reaches STARVE_LIM; s_hold_o = 1.
- Transitions:
  - IDLE→WAIT on the first capture.
  - WAIT/FORCE→IDLE when the FIFO becomes empty (pop or invalidation).
  - FORCE→WAIT on a grant that leaves an entry.
- s_busy_o = FSM != IDLE.

## Timing
- Reset values: FIFO empty, counter 0, FSM IDLE, s_busy_o/s_hold_o/s_fixed_o/s_drop_o = 0. s_rf_* follow WB inputs during and after reset.
- Capture latency: an error reported in cycle t gives its earliest repair write in cycle t+1.
- Pop and capture in the same cycle are allowed. Free-slot count uses post-pop occupancy, so a full FIFO can accept one new entry while popping.
- Simultaneous invalidation of the head and a grant cannot happen, because a grant requires s_wb_we_i = 0.
- s_hold_o is registered and asserts the cycle after the counter hits STARVE_LIM. It deasserts the cycle after the grant or after the FIFO empties.
- Counter saturates at STARVE_LIM; width is $clog2(STARVE_LIM+1).
- Reset mid-operation discards all entries with no write issued.

## Structure
- p_hardisc package:
  - rf_add (existing)
  - new constant RFFIX_STARVE_LIM = 4
  - new enum rffix_state {RFFIX_IDLE, RFFIX_WAIT, RFFIX_FORCE}
- One sub-module, rf_fix_queue: 2-entry FIFO with address-match invalidate, merge and push/pop ports. rf_fix_ctrl holds the FSM, counter and write-port mux.
- The block is instantiated once, non-replicated.

## Test plan
- Single fix: s_ce_i=01, rs1=5, val1=0xDEADBEEF, WB idle → cycle t+1: s_rf_we_o=1, rd=5, val=0xDEADBEEF, s_fixed_o=1; t+2 s_busy_o=0.
- Dual error and merge: s_ce_i=11 with rs1=3, rs2=3 → exactly one write, to x3. Then s_ce_i=11 with rs1=3, rs2=7 → writes to x3 then x7 in consecutive cycles.
- Overflow: two entries pending with WB busy; new CE on x9 → x9 not queued, s_drop_o=1 for one cycle.
- Invalidation: x4 pending, WB writes x4=0x1 → entry cleared; no repair write to x4 ever; s_busy_o=0 the next cycle.
- Starvation: entry pending with s_wb_we_i=1 continuously (different rd) → s_hold_o=1 after 4 denied cycles. Drop s_wb_we_i → repair granted, and s_hold_o=0 one cycle later.
- Reset mid-WAIT: s_resetn_i=0 for one cycle → all outputs reset; no repair write after release.
